// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared FSM state type and width default for the serial full subtractor
package full_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// rtl/fullsubtractor.sv - combinational 1-bit full subtractor (a - b - bin)
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow out when a < b + bin: either a=0,b=1, or a==b with a borrow coming in.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/full_subtractor_serial.sv
// rtl/full_subtractor_serial.sv - bit-serial X - Y - Bin, one bit per cycle; optional V via FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
module full_subtractor_serial
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t state_q, state_d;

  // Captured operands; bits are picked out by the index, never shifted.
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             brw_q, brw_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Partial result builds up here so D only ever shows whole results.
  logic [WIDTH-1:0] sh_q, sh_d;

  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
  logic             v_q, v_d;
`endif

  logic fs_d;
  logic fs_bout;

  fullsubtractor u_fs (
    .a    (x_q[idx_q]),
    .b    (y_q[idx_q]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state logic: capture in IDLE, one bit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    brw_d   = brw_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
    v_d     = v_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = X;
          y_d     = Y;
          brw_d   = Bin;
          idx_d   = '0;
          sh_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sh_d[idx_q] = fs_d;
        brw_d       = fs_bout;
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          d_d     = sh_d;
          bout_d  = fs_bout;
          idx_d   = '0;
          state_d = DONE;
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
          // Operands differ in sign and the result sign differs from the minuend.
          v_d = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (x_q[WIDTH-1] ^ fs_d);
`endif
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      brw_q   <= 1'b0;
      idx_q   <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      brw_q   <= brw_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
      v_q     <= v_d;
`endif
    end
  end

  // Handshake flags come straight from the state; results from their registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    D         = d_q;
    Bout      = bout_q;
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
    V         = v_q;
`endif
  end

endmodule

// File: tb/tb_full_subtractor_serial.sv
// tb/tb_full_subtractor_serial.sv - directed and exhaustive checks of the serial full subtractor
module tb_full_subtractor_serial;

  localparam int W = 4;
  localparam int N = 2 ** (2 * W + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Bin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         out_valid;
  logic         out_ready;
  logic         V;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_subtractor_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .Y         (Y),
    .Bin       (Bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .Bout      (Bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
    ,
    .V         (V)
`endif
  );

`ifndef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
  assign V = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one operation in IDLE, then count edges until the result appears.
  task automatic start_and_wait(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic b, output int lat);
    X = x; Y = y; Bin = b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0; Bin = 1'b0;
    tick; tick;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (D !== 4'h0) begin miscompares++; $display("FAIL reset_D got %h want 0", D); end
    vectors++;
    if (Bout !== 1'b0) begin miscompares++; $display("FAIL reset_Bout got %b want 0", Bout); end
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b0;
    X = 4'h9; Y = 4'h3; Bin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_busy got in_ready=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 50) begin tick; lat++; end
    vectors++;
    if (lat !== W) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    vectors++;
    if (D !== 4'h6 || Bout !== 1'b0) begin
      miscompares++; $display("FAIL basic_result got D=%h Bout=%b want D=6 Bout=0", D, Bout);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 4'h6) begin
      miscompares++;
      $display("FAIL basic_release got in_ready=%b out_valid=%b D=%h want 1 0 6", in_ready, out_valid, D);
    end
  endtask

  task automatic test_wrap;
    logic [W-1:0] xs [4] = '{4'h3, 4'h0, 4'hF, 4'hF};
    logic [W-1:0] ys [4] = '{4'h9, 4'h0, 4'h0, 4'hF};
    logic         bs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ed [4] = '{4'hA, 4'hF, 4'hF, 4'hF};
    logic         eb [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(xs[i], ys[i], bs[i], lat);
      vectors++;
      if (lat !== W || D !== ed[i] || Bout !== eb[i]) begin
        miscompares++;
        $display("FAIL wrap_%0d got lat=%0d D=%h Bout=%b want lat=%0d D=%h Bout=%b",
                 i, lat, D, Bout, W, ed[i], eb[i]);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_hold;
    int lat;
    out_ready = 1'b0;
    start_and_wait(4'h2, 4'h7, 1'b1, lat);
    X = 4'h1; Y = 4'h1; Bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (D !== 4'hA || Bout !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d got D=%h Bout=%b out_valid=%b in_ready=%b want A 1 1 0",
                 i, D, Bout, out_valid, in_ready);
      end
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 4'hA) begin
      miscompares++;
      $display("FAIL hold_release got in_ready=%b out_valid=%b D=%h want 1 0 A", in_ready, out_valid, D);
    end
    tick;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL hold_no_restart got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic seen;
    out_ready = 1'b1;
    X = 4'hF; Y = 4'h1; Bin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 4'h0 || Bout !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state got in_ready=%b out_valid=%b D=%h Bout=%b want 1 0 0 0",
               in_ready, out_valid, D, Bout);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_result got out_valid seen=%b want 0", seen); end
    out_ready = 1'b0;
  endtask

`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
  task automatic test_overflow;
    int lat;
    start_and_wait(4'h7, 4'hF, 1'b0, lat);
    vectors++;
    if (D !== 4'h8 || Bout !== 1'b1 || V !== 1'b1) begin
      miscompares++; $display("FAIL ovf_7_F got D=%h Bout=%b V=%b want 8 1 1", D, Bout, V);
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
    start_and_wait(4'h5, 4'h2, 1'b0, lat);
    vectors++;
    if (D !== 4'h3 || Bout !== 1'b0 || V !== 1'b0) begin
      miscompares++; $display("FAIL ovf_5_2 got D=%h Bout=%b V=%b want 3 0 0", D, Bout, V);
    end
    out_ready = 1'b1; tick; out_ready = 1'b0;
  endtask
`endif

  task automatic test_back_to_back;
    logic [W+1:0] expq [$];
    logic [W+1:0] exp_v;
    logic [W+1:0] got;
    logic [W:0]   diff;
    logic [W-1:0] xx, yy;
    logic         bb, vv;
    int issued = 0;
    int done = 0;
    for (int cyc = 0; cyc < 20000 && done < N; cyc++) begin
      if (issued < N) begin
        xx = issued[W-1:0];
        yy = issued[2*W-1:W];
        bb = issued[2*W];
        X = xx; Y = yy; Bin = bb;
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = $urandom_range(0, 1) == 1;
      if (in_valid && in_ready) begin
        diff = {1'b0, xx} - {1'b0, yy} - {{W{1'b0}}, bb};
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
        vv = (xx[W-1] ^ yy[W-1]) & (xx[W-1] ^ diff[W-1]);
`else
        vv = 1'b0;
`endif
        expq.push_back({vv, diff[W], diff[W-1:0]});
        issued++;
      end
      if (out_valid && out_ready) begin
        vectors++;
        got = {V, Bout, D};
        if (expq.size() == 0) begin
          miscompares++; $display("FAIL sweep_duplicate got {V,Bout,D}=%h with nothing outstanding", got);
        end else begin
          exp_v = expq.pop_front();
          if (got !== exp_v) begin
            miscompares++; $display("FAIL sweep_result#%0d got {V,Bout,D}=%h want %h", done, got, exp_v);
          end
        end
        done++;
      end
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (done !== N || expq.size() !== 0) begin
      miscompares++;
      $display("FAIL sweep_count got %0d results, %0d pending want %0d results, 0 pending", done, expq.size(), N);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_hold;
    test_reset_mid_run;
`ifdef FULL_SUBTRACTOR_SERIAL_OVERFLOW_EN
    test_overflow;
`endif
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
